// File: rtl/sequenciador_requisicoes_if.sv
// Controller-side start/ready/valid handshake bundle.
// The requester uses master; the datapath controller uses slave.
interface sequenciador_requisicoes_if #(
   parameter int WIDTH = 8
);
   logic             op_ready;
   logic             op_valid;
   logic [WIDTH-1:0] op_result;
   logic             op_start;
   logic [WIDTH-1:0] op_x;

   modport master (
      input  op_ready, op_valid, op_result,
      output op_start, op_x
   );

   modport slave (
      output op_ready, op_valid, op_result,
      input  op_start, op_x
   );
endinterface

// File: rtl/sequenciador_requisicoes.sv
// Requester for the datapath control unit: issues one operand,
// waits for the result pulse and hands it downstream.
module sequenciador_requisicoes #(
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 15,
   parameter int CW      = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_x,
   output logic             in_ready,
   sequenciador_requisicoes_if.master ctl,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_result,
   input  logic             out_ready,
   output logic             busy,
   output logic [CW-1:0]    lat,
   output logic             err,
   input  logic             clear_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   localparam logic [CW-1:0] TO = CW'(TIMEOUT);

   state_t           state, state_nxt;
   logic [CW-1:0]    counter;
   logic [CW-1:0]    cnt_inc;
   logic [WIDTH-1:0] op_x_q;
   logic             capture, start, done, tmo, drained, err_set;

   assign cnt_inc = counter + CW'(1);
   assign ctl.op_x = op_x_q;
   assign busy = (state != IDLE);

   always_comb begin
      state_nxt    = state;
      capture      = 1'b0;
      start        = 1'b0;
      done         = 1'b0;
      tmo          = 1'b0;
      drained      = 1'b0;
      in_ready     = (state == IDLE);
      ctl.op_start = (state == ISSUE) && ctl.op_ready;
      unique case (state)
         IDLE: if (in_valid) begin
            capture   = 1'b1;
            state_nxt = ISSUE;
         end
         ISSUE: if (ctl.op_ready) begin
            start     = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: if (ctl.op_valid) begin
            done      = 1'b1;
            state_nxt = DRAIN;
         end else if (cnt_inc == TO) begin
            tmo       = 1'b1;
            state_nxt = IDLE;
         end
         DRAIN: if (out_ready) begin
            drained   = 1'b1;
            state_nxt = IDLE;
         end
      endcase
      // a result pulse outside WAIT is a protocol violation
      err_set = tmo || (ctl.op_valid && (state != WAIT));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         op_x_q     <= '0;
         out_result <= '0;
         lat        <= '0;
         counter    <= '0;
         out_valid  <= 1'b0;
         err        <= 1'b0;
      end else begin
         state <= state_nxt;
         if (capture)
            op_x_q <= in_x;
         if (start)
            counter <= '0;
         else if (state == WAIT)
            counter <= cnt_inc;
         if (done) begin
            out_result <= ctl.op_result;
            out_valid  <= 1'b1;
            lat        <= cnt_inc;
         end else if (drained) begin
            out_valid <= 1'b0;
         end
         if (err_set)
            err <= 1'b1;
         else if (clear_err)
            err <= 1'b0;
      end
   end

endmodule

// File: doc/sequenciador_requisicoes.md
Name: sequenciador_requisicoes

Overview:
- Requester side of the start/ready/valid handshake exposed by the datapath control unit.
- Accepts one operand at a time from an upstream producer and holds it stable on op_x for the whole operation.
- Fires a single-cycle op_start when the controller reports op_ready, then waits for the one-cycle op_valid pulse and captures op_result.
- Presents the result downstream with a valid/ready handshake; flags timeouts and protocol errors.

Parameters:
- WIDTH, 8, bit width of operand and result.
- TIMEOUT, 15, maximum WAIT cycles before abort (1..2^CW-1).
- CW, 4, width of latency/timeout counter.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream operand valid.
- in_x  input  WIDTH  upstream operand.
- in_ready  output  1  block can accept operand.
- op_ready  input  1  controller idle (accepts start).
- op_valid  input  1  controller result valid, one-cycle pulse.
- op_result  input  WIDTH  datapath result.
- op_start  output  1  start request to controller.
- op_x  output  WIDTH  operand driven to datapath, registered.
- out_valid  output  1  captured result available.
- out_result  output  WIDTH  captured result, registered.
- out_ready  input  1  downstream accepts result.
- busy  output  1  state != IDLE.
- lat  output  CW  cycles from start acceptance to op_valid, last successful op.
- err  output  1  sticky error: timeout or unexpected op_valid.
- clear_err  input  1  clears err (synchronous).

Behaviour:
- Reset: one clock, synchronous, active-high. When reset is high at a rising edge:
  - state <= IDLE;
  - op_x, out_result, lat, counter <= 0;
  - out_valid, err <= 0.
  - After reset, op_start=0, in_ready=1, busy=0. Reset overrides every other input, including in mid-operation.
- States: IDLE, ISSUE, WAIT, DRAIN; 2-bit encoding.
- in_ready = (state==IDLE); op_start = (state==ISSUE) && op_ready. Both are combinational from state and inputs.
- IDLE: on in_valid && in_ready, op_x <= in_x and go to ISSUE. op_x is not otherwise written.
- ISSUE:
  - op_start follows op_ready, so no start is issued while the controller is busy.
  - On the edge with op_start=1: counter <= 0, go to WAIT. op_start is high for exactly one cycle per operation.
- WAIT:
  - op_start=0; counter increments every cycle.
  - On op_valid: out_result <= op_result, out_valid <= 1, lat <= counter+1, go to DRAIN. With the standard controller, op_valid arrives 7 cycles after the start edge, giving lat=7.
  - If counter+1 == TIMEOUT and op_valid=0: err <= 1, go to IDLE; out_valid stays 0 and lat is unchanged.
  - If op_valid and the timeout coincide, op_valid wins.
- DRAIN:
  - out_valid=1; out_result is held stable.
  - On out_ready: out_valid <= 0, go to IDLE.
  - in_valid is ignored (in_ready=0).
- op_valid while not in WAIT: ignored for data, err <= 1.
- err is sticky; clear_err clears it. If clear_err coincides with a new error event, set wins.
- op_x is held from operand capture until the next IDLE capture; it never changes while busy.
- Throughput: at most one operation in flight; minimum one idle cycle between operations.

Test Plan:
1. Reset, then in_x=8'd5 with in_valid for 1 cycle; controller model returns op_result=8'd42 with op_valid 7 cycles after the start edge -> op_start high exactly 1 cycle, op_x=5 throughout, out_valid=1 with out_result=42, lat=7, err=0.
2. Hold op_ready=0 for 3 cycles after operand capture -> op_start stays 0; asserts for 1 cycle on the first op_ready=1 cycle, and state advances to WAIT only then.
3. TIMEOUT=15, op_valid never asserted -> after 15 WAIT cycles: err=1, state IDLE, in_ready=1, out_valid=0, lat unchanged.
4. out_ready held low 5 cycles in DRAIN with in_valid=1 and in_x=9 -> out_valid/out_result stable, in_ready=0, op_x unchanged. Raise out_ready -> IDLE next cycle, then operand 9 accepted.
5. Assert reset in cycle 3 of WAIT -> next cycle: busy=0, out_valid=0, op_x=0, err=0, lat=0. A stray op_valid pulse afterwards -> err=1, no out_valid.
6. err=1, then clear_err=1 for 1 cycle -> err=0. Repeat with clear_err coinciding with a stray op_valid -> err remains 1.
